// File: rtl/mem_read_fsm.sv
// Read-side sequencer for the ToF sample BRAM: walks port B from address 0 to DEPTH-1
// on a start rise and streams each word out over valid/ready, pulsing done per pass.
module mem_read_fsm #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 63,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        LAT_INIT  = 4'(RD_LAT - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [3:0]          lat_cnt, lat_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                start_q;
  logic                start_rise;
  logic                is_last;

  assign start_rise = start & ~start_q;
  assign is_last    = (addr == LAST_ADDR);
  assign addrb      = addr;

  // start_q resets high so a start level held through reset cannot look like a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr    <= '0;
      lat_cnt <= '0;
      m_data  <= '0;
      start_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      lat_cnt <= lat_nxt;
      m_data  <= data_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    lat_nxt   = lat_cnt;
    data_nxt  = m_data;
    enb       = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        addr_nxt = '0;
        if (start_rise) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        enb       = 1'b1;
        lat_nxt   = LAT_INIT;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt != '0) begin
          lat_nxt = lat_cnt - 4'd1;
        end else begin
          data_nxt  = doutb;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        m_valid = 1'b1;
        m_last  = is_last;
        if (m_ready) begin
          if (is_last) begin
            state_nxt = ST_DONE;
          end else begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        addr_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_read_fsm.md
Name: mem_read_fsm

Overview:
Read-side sequencer for the ToF sample BRAM. The write FSM fills this BRAM and raises all_data_written. This block then reads the BRAM port B from address 0 to DEPTH-1, one word at a time, and presents each word on a valid/ready stream to the plane-calculation datapath. It honours the BRAM read latency, holds each word under backpressure, and pulses done at the end of each pass.

Parameters:
ADDR_W, 6, BRAM port-B address width.
DATA_W, 16, BRAM data width and stream data width.
DEPTH, 63, words per pass; legal range 1..2^ADDR_W.
RD_LAT, 2, BRAM read latency in cycles; legal range 1..15.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
start  in  1  level input, normally all_data_written; a pass begins on its rising edge.
addrb  out  ADDR_W  BRAM port-B address.
enb  out  1  BRAM port-B read enable.
doutb  in  DATA_W  BRAM port-B read data.
m_data  out  DATA_W  stream data; a registered copy of doutb.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from the consumer.
m_last  out  1  high with m_valid on the word at address DEPTH-1.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE, addr=0, lat_cnt=0, m_data=0.
  - All outputs are 0.
  - start_q (registered start) resets to 1, so a start held high through reset does not trigger a pass; a fresh 0->1 transition is required.
- Start detection: start_rise = start & ~start_q. It is evaluated only in IDLE. While busy, rises are ignored and are not queued.
- States:
  - IDLE: addr=0. On start_rise go to ISSUE.
  - ISSUE: exactly one cycle. enb=1, addrb=addr. Set lat_cnt=RD_LAT-1. Go to WAIT.
  - WAIT: lasts RD_LAT cycles. In each cycle, if lat_cnt!=0 then decrement it; else capture doutb into m_data and go to PRESENT.
  - PRESENT: m_valid=1 and m_data is held stable until the handshake (m_valid & m_ready).
    - On handshake with addr==DEPTH-1: go to DONE.
    - On other handshakes: addr=addr+1, go to ISSUE.
    - Without handshake: stay in PRESENT.
  - DONE: done=1 for one cycle, addr cleared to 0, go to IDLE.
- Output decoding:
  - enb is high only in ISSUE. addrb equals addr in every state; BRAM samples it only when enb=1.
  - m_valid is high only in PRESENT. m_last = PRESENT & (addr==DEPTH-1).
- Latency and throughput:
  - If start rises at cycle S: ISSUE at S+1, first m_valid at S+RD_LAT+2 (S+4 at default).
  - Minimum 2+RD_LAT cycles per word with m_ready tied high (4 at default).
  - Minimum pass length with m_ready tied high: DEPTH*(2+RD_LAT)+1 cycles including DONE.
- Arithmetic: addr is ADDR_W bits and never exceeds DEPTH-1, so no wrap occurs. lat_cnt is 4 bits.
- Boundary conditions:
  - DEPTH=1: a single word carries m_last, then DONE.
  - RD_LAT=1: WAIT is a single cycle and captures doutb immediately.
  - m_ready high before m_valid has no effect.
  - m_ready dropping while m_valid is high: m_valid, m_data and m_last must not change.
  - start falling mid-pass does not abort the pass.
  - start still high after DONE does not retrigger; a new rise is needed.
  - A start rise in the same cycle as DONE is ignored.
- Reset mid-pass: applies reset values on the next edge. Any partially presented word is dropped and done is not pulsed.

Test Plan:
- DEPTH=4, RD_LAT=2, BRAM model holding A0..A3, m_ready=1, start rise at cycle 10 -> enb pulses at cycles 11, 15, 19, 23 with addrb 0..3. m_valid at cycles 14, 18, 22, 26 with m_data A0..A3. m_last only at cycle 26. done at cycle 27. busy high for cycles 11..27.
- Backpressure: m_ready low for 5 cycles while word 1 is presented -> m_data=A1 stable and m_valid held high throughout. No enb pulse until the handshake. Final output order is A0..A3 with no duplicates or drops.
- start held high after a full pass -> exactly one pass and one done pulse. Drop start then raise it again -> a second identical pass.
- start toggled during a pass, and a start rise coincident with DONE -> neither affects the current pass nor triggers a new one.
- Reset asserted while word 2 is in WAIT -> next cycle all outputs are 0 and state is IDLE. start held high across reset -> no pass.
- RD_LAT=1, DEPTH=1 -> m_valid 3 cycles after the start rise, with m_last=1. done follows the handshake by 1 cycle.
